// File: rtl/dinorun_pkg.sv
// dinorun_pkg: shared scheduler state type, LFSR taps and difficulty defaults
package dinorun_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, ISSUE, STALL} sched_state_e;

    localparam logic [15:0] LFSR_MASK       = 16'hB400;
    localparam int          GAP_INIT_DEF    = 90;
    localparam int          GAP_FLOOR_DEF   = 40;
    localparam int          GAP_STEP_DEF    = 5;
    localparam int          RAMP_FRAMES_DEF = 600;

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, reloaded with seed only on reset
module lfsr16
    import dinorun_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    // shift right every cycle, folding the taps in when a one falls out
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= seed;
        else       state <= (state >> 1) ^ (state[0] ? LFSR_MASK : 16'h0000);
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: decides when and into which free slot the next cactus spawns, ramps difficulty
module obstacle_scheduler
    import dinorun_pkg::*;
#(
    parameter int          N_SLOTS     = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          GAP_INIT    = GAP_INIT_DEF,
    parameter int          GAP_FLOOR   = GAP_FLOOR_DEF,
    parameter int          GAP_STEP    = GAP_STEP_DEF,
    parameter int          RAMP_FRAMES = RAMP_FRAMES_DEF,
    parameter int          JITTER_BITS = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               next_frame_i,
    input  logic               run_i,
    input  logic               clear_i,
    input  logic [N_SLOTS-1:0] slot_active_i,
    output logic [N_SLOTS-1:0] spawn_o,
    output logic [1:0]         type_o,
    output logic [8:0]         base_gap_o
);

    localparam logic [8:0] JITTER_MASK = 9'((1 << JITTER_BITS) - 1);

    sched_state_e       state_q, state_d;
    logic [8:0]         cnt_q, cnt_d, reload, stepped_gap;
    logic [9:0]         ramp_q;
    logic [N_SLOTS-1:0] free, pick, spawn_d;
    logic [1:0]         type_d;
    logic [15:0]        lfsr;
    logic               issue_now;

    lfsr16 u_lfsr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    assign free        = ~slot_active_i;
    assign pick        = free & (~free + N_SLOTS'(1));
    assign reload      = base_gap_o + (9'(lfsr) & JITTER_MASK);
    assign stepped_gap = (base_gap_o >= 9'(GAP_FLOOR + GAP_STEP)) ? base_gap_o - 9'(GAP_STEP) : 9'(GAP_FLOOR);
    assign issue_now   = (state_q == COUNT && next_frame_i && cnt_q == '0) || state_q == STALL;

    // next state, gap countdown and spawn decision; the pulse is registered on entry to ISSUE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        spawn_d = '0;
        type_d  = type_o;
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!run_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE || state_q == ISSUE) begin
            state_d = COUNT;
            cnt_d   = reload;
        end else if (issue_now) begin
            state_d = (|free) ? ISSUE : STALL;
            spawn_d = pick;
            type_d  = (|free) ? lfsr[1:0] : type_o;
        end else if (state_q == COUNT && next_frame_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // scheduler state and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            spawn_o <= '0;
            type_o  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spawn_o <= spawn_d;
            type_o  <= type_d;
        end
    end

    // difficulty ramp: every RAMP_FRAMES running frames the base gap shrinks toward the floor
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            ramp_q     <= '0;
            base_gap_o <= 9'(GAP_INIT);
        end else if (next_frame_i && state_q != IDLE) begin
            if (ramp_q == 10'(RAMP_FRAMES - 1)) begin
                ramp_q     <= '0;
                base_gap_o <= stepped_gap;
            end else begin
                ramp_q <= ramp_q + 1'b1;
            end
        end
    end

endmodule
